alu_cntrl: RTL and testbench

- Combined ALU-control decoder and 32-bit integer ALU for the RV32I single-cycle core.
- Maps main-control alu_op plus instruction funct3/funct7 to a 4-bit operation code, then executes that operation on two 32-bit operands.
- Produces a registered result, a zero flag (used for branch-on-equal) and the registered operation code.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_core.sv | 33 +++
 rtl/alu_cntrl.sv | 44 ++++
 tb/tb_alu_cntrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - operation encodings, alu_op values and the ALU-control decode function
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam logic [1:0] ALU_OP_MEM = 2'b00;
    localparam logic [1:0] ALU_OP_BR  = 2'b01;
    localparam logic [1:0] ALU_OP_R   = 2'b10;
    localparam logic [1:0] ALU_OP_I   = 2'b11;

    // funct fields are only inspected for R/I types so unknowns on them cannot leak for mem/branch
    function automatic logic [3:0] decode_op(input logic [1:0] alu_op,
                                             input logic [2:0] funct3,
                                             input logic       funct7_b5);
        logic [3:0] op;
        op = OP_ADD;
        if (alu_op == ALU_OP_MEM) begin
            op = OP_ADD;
        end else if (alu_op == ALU_OP_BR) begin
            op = OP_SUB;
        end else begin
            case (funct3)
                3'b000:  op = (alu_op == ALU_OP_R && funct7_b5) ? OP_SUB : OP_ADD;
                3'b001:  op = OP_SLL;
                3'b010:  op = OP_SLT;
                3'b011:  op = OP_SLTU;
                3'b100:  op = OP_XOR;
                3'b101:  op = funct7_b5 ? OP_SRA : OP_SRL;
                3'b110:  op = OP_OR;
                default: op = OP_AND;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational 32-bit integer datapath selected by a 4-bit operation code
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << shamt;
            OP_SRL:  y = a >> shamt;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
            OP_SRA:  y = $signed(a) >>> shamt;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_cntrl.sv
// rtl/alu_cntrl.sv - ALU-control decode plus ALU with registered operation, result and zero flag
module alu_cntrl
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    output logic [3:0]      operation,
    output logic [XLEN-1:0] result,
    output logic            Z
);

    logic [3:0]      next_op;
    logic [XLEN-1:0] next_result;

    assign next_op = decode_op(alu_op, funct3, funct7[5]);

    alu_core #(.XLEN(XLEN)) u_core (
        .op (next_op),
        .a  (operand1),
        .b  (operand2),
        .y  (next_result)
    );

    // Z is derived from the same next-state value so it never disagrees with result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            operation <= 4'b0000;
            result    <= '0;
            Z         <= 1'b0;
        end else begin
            operation <= next_op;
            result    <= next_result;
            Z         <= (next_result == '0);
        end
    end

endmodule

// File: tb/tb_alu_cntrl.sv
// tb/tb_alu_cntrl.sv - directed vectors with a per-cycle reference model for alu_cntrl
module tb_alu_cntrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic [6:0]  funct7 = 7'b0000000;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic [3:0]  operation;
    logic [31:0] result;
    logic        Z;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit model_armed = 1'b0;

    alu_cntrl #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_op    (alu_op),
        .funct3    (funct3),
        .funct7    (funct7),
        .operand1  (operand1),
        .operand2  (operand2),
        .operation (operation),
        .result    (result),
        .Z         (Z)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_op(input logic [1:0] ao, input logic [2:0] f3, input logic [6:0] f7);
        logic [3:0] r_type [8];
        r_type = '{4'd2, 4'd4, 4'd7, 4'd8, 4'd3, 4'd5, 4'd1, 4'd0};
        if (ao == 2'b00) return 4'd2;
        if (ao == 2'b01) return 4'd6;
        if (f3 == 3'd0 && ao == 2'b10 && f7 == 7'b0100000) return 4'd6;
        if (f3 == 3'd5 && f7 == 7'b0100000) return 4'd13;
        return r_type[f3];
    endfunction

    function automatic logic [31:0] model_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] wide;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'd3:  return a ^ b;
            4'd4:  return 32'(64'(a) * (64'd1 << b[4:0]));
            4'd5:  return 32'(64'(a) / (64'd1 << b[4:0]));
            4'd6:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd8:  return (64'(a) < 64'(b)) ? 32'd1 : 32'd0;
            4'd13: begin
                wide = {{32{a[31]}}, a} >> b[4:0];
                return wide[31:0];
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Continuous model comparison: expectation formed from inputs seen at each edge
    always @(posedge clk) begin
        logic [3:0]  e_op;
        logic [31:0] e_res;
        logic        e_z;
        bit          armed;
        armed = model_armed;
        if (!rst_n) begin
            e_op = 4'd0; e_res = 32'd0; e_z = 1'b0;
        end else begin
            e_op  = model_op(alu_op, funct3, funct7);
            e_res = model_res(e_op, operand1, operand2);
            e_z   = (e_res == 32'd0);
        end
        #1;
        if (armed) begin
            check("model_operation", {28'd0, operation}, {28'd0, e_op});
            check("model_result", result, e_res);
            check("model_z", {31'd0, Z}, {31'd0, e_z});
        end
    end

    task automatic drive(input logic [1:0] ao, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_op = ao; funct3 = f3; funct7 = f7; operand1 = a; operand2 = b;
        @(posedge clk);
        #2;
    endtask

    task automatic vec(input string name, input logic [1:0] ao, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] e_op, input logic [31:0] e_res, input logic e_z);
        drive(ao, f3, f7, a, b);
        check({name, "_op"}, {28'd0, operation}, {28'd0, e_op});
        check({name, "_res"}, result, e_res);
        check({name, "_z"}, {31'd0, Z}, {31'd0, e_z});
    endtask

    initial begin
        rst_n = 1'b0;
        model_armed = 1'b1;
        @(posedge clk); #2;
        check("reset_op", {28'd0, operation}, 32'd0);
        check("reset_res", result, 32'd0);
        check("reset_z", {31'd0, Z}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vec("mem_add", 2'b00, 3'bxxx, 7'bxxxxxxx, 32'd50, 32'd50, 4'b0010, 32'd100, 1'b0);
        vec("br_sub", 2'b01, 3'bxxx, 7'bxxxxxxx, 32'd50, 32'd50, 4'b0110, 32'd0, 1'b1);
        vec("r_sub", 2'b10, 3'b000, 7'b0100000, 32'd50, 32'd50, 4'b0110, 32'd0, 1'b1);
        vec("r_add", 2'b10, 3'b000, 7'b0000000, 32'd50, 32'd50, 4'b0010, 32'd100, 1'b0);
        vec("r_and", 2'b10, 3'b111, 7'b0000000, 32'd1, 32'd0, 4'b0000, 32'd0, 1'b1);
        vec("r_or", 2'b10, 3'b110, 7'b0000000, 32'd1, 32'd0, 4'b0001, 32'd1, 1'b0);
        vec("r_slt_pos", 2'b10, 3'b010, 7'b0000000, 32'd100, 32'd50, 4'b0111, 32'd0, 1'b1);
        vec("r_slt_neg", 2'b10, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0);
        vec("r_sltu", 2'b10, 3'b011, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 4'b1000, 32'd0, 1'b1);
        vec("r_sll", 2'b10, 3'b001, 7'b0000000, 32'h8000_0000, 32'h21, 4'b0100, 32'h0, 1'b1);
        vec("r_srl", 2'b10, 3'b101, 7'b0000000, 32'h8000_0000, 32'h21, 4'b0101, 32'h4000_0000, 1'b0);
        vec("r_sra", 2'b10, 3'b101, 7'b0100000, 32'h8000_0000, 32'h21, 4'b1101, 32'hC000_0000, 1'b0);
        vec("i_add_f7", 2'b11, 3'b000, 7'b0100000, 32'h8000_0000, 32'h21, 4'b0010, 32'h8000_0021, 1'b0);
        vec("r_xor", 2'b10, 3'b100, 7'b0000000, 32'hF0F0_1234, 32'h0FF0_1234, 4'b0011, 32'hFF00_0000, 1'b0);
        vec("add_wrap", 2'b00, 3'b000, 7'b0000000, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1);
        vec("sub_wrap", 2'b01, 3'b000, 7'b0000000, 32'd0, 32'd1, 4'b0110, 32'hFFFF_FFFF, 1'b0);
        vec("i_srai", 2'b11, 3'b101, 7'b0100000, 32'hF000_0000, 32'd4, 4'b1101, 32'hFF00_0000, 1'b0);

        vec("pre_rst_add", 2'b00, 3'b000, 7'b0000000, 32'd50, 32'd50, 4'b0010, 32'd100, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #2;
        check("mid_rst_op", {28'd0, operation}, 32'd0);
        check("mid_rst_res", result, 32'd0);
        check("mid_rst_z", {31'd0, Z}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("post_rst_op", {28'd0, operation}, 32'd2);
        check("post_rst_res", result, 32'd100);
        check("post_rst_z", {31'd0, Z}, 32'd0);

        @(negedge clk);
        model_armed = 1'b0;
        @(posedge clk); #3;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
